// File: rtl/mem_cache_ctrl.sv
// mem_cache_ctrl
// Miss-handling sequencer for a 4-way set-associative L1 data cache in the MEM stage.
// On a load/store miss it stalls the pipeline and picks a victim way. The victim is the
// lowest invalid way, or else the per-set tree pseudo-LRU choice. A dirty victim is
// written back to L2 as 4 words. The line is then refilled from L2 as 4 words, one word
// per handshake. The cache arrays live in the cache datapath; this block only sequences
// them.
//
// Optional build macro: MEM_CACHE_PERF_EN adds the 32-bit outputs perf_hits, perf_misses
// and perf_wbs.
//
// Ports
//   CLK, RST_N                  clock, synchronous active-low reset
//   cpu_rd, cpu_wr, cpu_addr    MEM-stage request
//   hit, hit_way                cache lookup result for cpu_addr
//   set_valid, set_dirty        valid/dirty bits of the addressed set
//   victim_tag, wb_word         victim line tag and the word selected by word_sel
//   stall                       freeze pipeline
//   victim_way, word_sel        array selects for writeback read / fill write
//   line_inval, fill_we         invalidate victim; write refill word
//   line_commit                 set valid, write tag, clear dirty
//   l2_req/l2_we/l2_addr/l2_wdata/l2_ack/l2_rdata   one-word L2 handshake
//
// state  | meaning
// IDLE   | serving hits, detecting misses
// WB     | writing back dirty victim words 0..3
// RF     | refilling words 0..3 from L2
// COMMIT | marking the refilled line valid and clean

module mem_cache_ctrl #(
    parameter int NUM_SETS = 4,
    parameter int INDEX_W  = 2,
    parameter int TAG_W    = 26
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [31:0]       cpu_addr,
    input  logic              hit,
    input  logic [1:0]        hit_way,
    input  logic [3:0]        set_valid,
    input  logic [3:0]        set_dirty,
    input  logic [TAG_W-1:0]  victim_tag,
    input  logic [31:0]       wb_word,
    output logic              stall,
    output logic [1:0]        victim_way,
    output logic [1:0]        word_sel,
    output logic              line_inval,
    output logic              fill_we,
    output logic              line_commit,
    output logic              l2_req,
    output logic              l2_we,
    output logic [31:0]       l2_addr,
    output logic [31:0]       l2_wdata,
    input  logic              l2_ack,
    input  logic [31:0]       l2_rdata
`ifdef MEM_CACHE_PERF_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses,
    output logic [31:0]       perf_wbs
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_RF, S_COMMIT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_beat;
    logic [TAG_W-1:0]   r_tag;
    logic [INDEX_W-1:0] r_idx;
    logic [1:0]         r_victim;
    logic               r_rf_first;
    logic [2:0]         r_plru [NUM_SETS];

    logic               w_req;
    logic               w_miss;
    logic               w_last;
    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [2:0]         w_plru_cur;
    logic [1:0]         w_plru_way;
    logic [1:0]         w_new_victim;
    logic               w_victim_dirty;
    logic               w_unused;

    // Tree PLRU: b0 selects the pair, b1/b2 select within the pair.
    // A touch points the tree away from the way just used.
    function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] way);
        logic [2:0] n;
        n = b;
        if (way[1] == 1'b0) begin
            n[0] = 1'b1;
            n[1] = (way == 2'd0);
        end else begin
            n[0] = 1'b0;
            n[2] = (way == 2'd2);
        end
        return n;
    endfunction

    assign w_req  = cpu_rd | cpu_wr;
    assign w_idx  = cpu_addr[4 +: INDEX_W];
    assign w_tag  = cpu_addr[31 -: TAG_W];
    assign w_miss = (r_state == S_IDLE) & w_req & ~hit;
    assign w_last = l2_ack & (r_beat == 2'd3);

    // The low address bits and the refill data are consumed by the cache datapath.
    assign w_unused = &{1'b0, cpu_addr[3:0], l2_rdata};

    always_comb begin
        w_plru_cur = r_plru[w_idx];
        w_plru_way = w_plru_cur[0] ? (w_plru_cur[2] ? 2'd3 : 2'd2)
                                   : (w_plru_cur[1] ? 2'd1 : 2'd0);
        if (!set_valid[0])      w_new_victim = 2'd0;
        else if (!set_valid[1]) w_new_victim = 2'd1;
        else if (!set_valid[2]) w_new_victim = 2'd2;
        else if (!set_valid[3]) w_new_victim = 2'd3;
        else                    w_new_victim = w_plru_way;
        w_victim_dirty = set_dirty[w_new_victim];
    end

    // state register
    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_miss) w_next = w_victim_dirty ? S_WB : S_RF;
            S_WB:     if (w_last) w_next = S_RF;
            S_RF:     if (w_last) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // outputs
    assign victim_way = r_victim;

    always_comb begin
        stall       = (r_state != S_IDLE) | w_miss;
        word_sel    = 2'd0;
        line_inval  = 1'b0;
        fill_we     = 1'b0;
        line_commit = 1'b0;
        l2_req      = 1'b0;
        l2_we       = 1'b0;
        l2_addr     = 32'd0;
        l2_wdata    = 32'd0;
        case (r_state)
            S_WB: begin
                l2_req   = 1'b1;
                l2_we    = 1'b1;
                l2_addr  = {victim_tag, r_idx, r_beat, 2'b00};
                l2_wdata = wb_word;
                word_sel = r_beat;
            end
            S_RF: begin
                l2_req     = 1'b1;
                l2_addr    = {r_tag, r_idx, r_beat, 2'b00};
                word_sel   = r_beat;
                line_inval = r_rf_first;
                fill_we    = l2_ack;
            end
            S_COMMIT: line_commit = 1'b1;
            default: ;
        endcase
    end

    // miss context, beat counter and PLRU state
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_beat     <= 2'd0;
            r_tag      <= '0;
            r_idx      <= '0;
            r_victim   <= 2'd0;
            r_rf_first <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) r_plru[s] <= 3'd0;
        end else begin
            if (w_miss) begin
                r_tag      <= w_tag;
                r_idx      <= w_idx;
                r_victim   <= w_new_victim;
                r_rf_first <= 1'b1;
            end
            if (r_state == S_RF) r_rf_first <= 1'b0;
            // beat wraps 3 -> 0 at the end of each phase
            if ((r_state == S_WB || r_state == S_RF) && l2_ack) r_beat <= r_beat + 2'd1;
            if (r_state == S_IDLE && w_req && hit)
                r_plru[w_idx] <= plru_touch(r_plru[w_idx], hit_way);
            if (r_state == S_COMMIT)
                r_plru[r_idx] <= plru_touch(r_plru[r_idx], r_victim);
        end
    end

`ifdef MEM_CACHE_PERF_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            perf_hits   <= 32'd0;
            perf_misses <= 32'd0;
            perf_wbs    <= 32'd0;
        end else begin
            if (r_state == S_IDLE && w_req && hit) perf_hits <= perf_hits + 32'd1;
            if (w_miss)                            perf_misses <= perf_misses + 32'd1;
            if (w_miss && w_victim_dirty)          perf_wbs <= perf_wbs + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Self-checking bench for mem_cache_ctrl: a per-cycle vector table for a cold load miss and
// a store miss, plus hand-written sequences for writeback, PLRU order, L2 wait states and
// reset during refill.

module tb_mem_cache_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr;
    logic        hit;
    logic [1:0]  hit_way;
    logic [3:0]  set_valid, set_dirty;
    logic [25:0] victim_tag;
    logic [31:0] wb_word;
    logic        stall;
    logic [1:0]  victim_way, word_sel;
    logic        line_inval, fill_we, line_commit;
    logic        l2_req, l2_we;
    logic [31:0] l2_addr, l2_wdata;
    logic        l2_ack;
    logic [31:0] l2_rdata;
`ifdef MEM_CACHE_PERF_EN
    logic [31:0] perf_hits, perf_misses, perf_wbs;
`endif

    int checks   = 0;
    int failures = 0;

    mem_cache_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .hit(hit), .hit_way(hit_way),
        .set_valid(set_valid), .set_dirty(set_dirty),
        .victim_tag(victim_tag), .wb_word(wb_word),
        .stall(stall), .victim_way(victim_way), .word_sel(word_sel),
        .line_inval(line_inval), .fill_we(fill_we), .line_commit(line_commit),
        .l2_req(l2_req), .l2_we(l2_we), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_ack(l2_ack), .l2_rdata(l2_rdata)
`ifdef MEM_CACHE_PERF_EN
        , .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_wbs(perf_wbs)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    logic [73:0] act;
    assign act = {stall, victim_way, word_sel, line_inval, fill_we, line_commit,
                  l2_req, l2_we, l2_addr, l2_wdata};

    function automatic logic [73:0] mk_exp(input logic s, input logic [1:0] vw,
                                           input logic [1:0] ws, input logic inv,
                                           input logic fil, input logic com, input logic rq,
                                           input logic we, input logic [31:0] ad,
                                           input logic [31:0] wd);
        return {s, vw, ws, inv, fil, com, rq, we, ad, wd};
    endfunction

    task automatic chk(input string nm, input logic [73:0] a, input logic [73:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr;
        logic        hit;
        logic [1:0]  hway;
        logic [3:0]  valid, dirty;
        logic        ack;
        logic [73:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rd, input logic wr, input logic [31:0] a, input logic h,
                       input logic [1:0] hw, input logic [3:0] v, input logic [3:0] d,
                       input logic ak, input logic [73:0] e);
        vec_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.hit = h; r.hway = hw;
        r.valid = v; r.dirty = d; r.ack = ak; r.exp = e;
        tbl.push_back(r);
    endtask

    // One complete miss from the IDLE miss cycle through the replay hit.
    task automatic do_miss(input string nm, input logic [31:0] a, input logic [3:0] v,
                           input logic [3:0] d, input logic [25:0] vt, input int waits,
                           input logic [1:0] way, input bit wb, input int exp_stall);
        int st;
        logic [1:0]  bb;
        logic [31:0] ea, ew;
        st = 0;
        @(negedge CLK);
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = a; hit = 1'b0; hit_way = 2'd0;
        set_valid = v; set_dirty = d; victim_tag = vt; l2_ack = 1'b0;
        #1;
        chk({nm, "_miss_cycle"}, {71'd0, stall, l2_req, line_inval}, {71'd0, 3'b100});
        if (stall) st++;
        for (int ph = (wb ? 0 : 1); ph < 2; ph++) begin
            for (int b = 0; b < 4; b++) begin
                for (int w = 0; w <= waits; w++) begin
                    @(negedge CLK);
                    bb       = b[1:0];
                    l2_ack   = (w == waits);
                    wb_word  = 32'hB000_0000 | b;
                    l2_rdata = 32'hC000_0000 | b;
                    ea = (ph == 0) ? {vt, a[5:4], bb, 2'b00} : {a[31:6], a[5:4], bb, 2'b00};
                    ew = (ph == 0) ? (32'hB000_0000 | b) : 32'd0;
                    #1;
                    chk($sformatf("%s_ph%0d_b%0d_w%0d", nm, ph, b, w), act,
                        mk_exp(1'b1, way, bb, (ph == 1 && b == 0 && w == 0),
                               (ph == 1 && w == waits), 1'b0, 1'b1, (ph == 0), ea, ew));
                    if (stall) st++;
                end
            end
        end
        @(negedge CLK);
        l2_ack = 1'b0;
        #1;
        chk({nm, "_commit"}, act, mk_exp(1'b1, way, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0));
        if (stall) st++;
        @(negedge CLK);
        hit = 1'b1; hit_way = way;
        #1;
        chk({nm, "_replay"}, act, mk_exp(1'b0, way, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
        chk({nm, "_stall_cycles"}, 74'(st), 74'(exp_stall));
    endtask

    initial begin
        RST_N = 1'b0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'd0; hit = 1'b0; hit_way = 2'd0;
        set_valid = 4'd0; set_dirty = 4'd0; victim_tag = 26'd0;
        wb_word = 32'hDEAD_BEEF; l2_ack = 1'b0; l2_rdata = 32'h1234_5678;

        // cold load 0x1000, all invalid -> way 0, reads 0x1000..0x100C
        add(0,0,32'h0000_0000,0,0,4'h0,4'h0,0, mk_exp(0,0,0,0,0,0,0,0,32'h0,0));
        add(1,0,32'h0000_1000,0,0,4'h0,4'h0,0, mk_exp(1,0,0,0,0,0,0,0,32'h0,0));
        add(1,0,32'h0000_1000,0,0,4'h0,4'h0,1, mk_exp(1,0,0,1,1,0,1,0,32'h1000,0));
        add(1,0,32'h0000_1000,0,0,4'h0,4'h0,1, mk_exp(1,0,1,0,1,0,1,0,32'h1004,0));
        add(1,0,32'h0000_1000,0,0,4'h0,4'h0,1, mk_exp(1,0,2,0,1,0,1,0,32'h1008,0));
        add(1,0,32'h0000_1000,0,0,4'h0,4'h0,1, mk_exp(1,0,3,0,1,0,1,0,32'h100C,0));
        add(1,0,32'h0000_1000,0,0,4'h0,4'h0,0, mk_exp(1,0,0,0,0,1,0,0,32'h0,0));
        add(1,0,32'h0000_1000,1,0,4'h1,4'h0,0, mk_exp(0,0,0,0,0,0,0,0,32'h0,0));
        // store miss with rd=wr=1, way 0 valid+dirty, victim way 1 is clean -> no writeback
        add(1,1,32'h0000_2010,0,0,4'h1,4'h1,0, mk_exp(1,0,0,0,0,0,0,0,32'h0,0));
        add(1,1,32'h0000_2010,0,0,4'h1,4'h1,1, mk_exp(1,1,0,1,1,0,1,0,32'h2010,0));
        add(1,1,32'h0000_2010,0,0,4'h1,4'h1,1, mk_exp(1,1,1,0,1,0,1,0,32'h2014,0));
        add(1,1,32'h0000_2010,0,0,4'h1,4'h1,1, mk_exp(1,1,2,0,1,0,1,0,32'h2018,0));
        add(1,1,32'h0000_2010,0,0,4'h1,4'h1,1, mk_exp(1,1,3,0,1,0,1,0,32'h201C,0));
        add(1,1,32'h0000_2010,0,0,4'h1,4'h1,0, mk_exp(1,1,0,0,0,1,0,0,32'h0,0));
        add(1,1,32'h0000_2010,1,1,4'h3,4'h1,0, mk_exp(0,1,0,0,0,0,0,0,32'h0,0));

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            cpu_rd = tbl[i].rd; cpu_wr = tbl[i].wr; cpu_addr = tbl[i].addr;
            hit = tbl[i].hit; hit_way = tbl[i].hway;
            set_valid = tbl[i].valid; set_dirty = tbl[i].dirty; l2_ack = tbl[i].ack;
            #1;
            chk($sformatf("table_row%0d", i), act, tbl[i].exp);
        end

`ifdef MEM_CACHE_PERF_EN
        chk("perf_hits",   74'(perf_hits),   74'd2);
        chk("perf_misses", 74'(perf_misses), 74'd2);
        chk("perf_wbs",    74'(perf_wbs),    74'd0);
`endif

        // set 0 full; PLRU after the way-0 refill points at way 2, which is dirty (tag 0x5)
        do_miss("t2_dirty", 32'h0000_3000, 4'hF, 4'b0100, 26'h5, 0, 2'd2, 1'b1, 10);

        // PLRU order on set 3: hits on ways 0..3 -> miss picks 0; then after hit on 0 -> 2
        for (int w = 0; w < 4; w++) begin
            @(negedge CLK);
            cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_4030; hit = 1'b1;
            hit_way = 2'(w); set_valid = 4'hF; set_dirty = 4'h0; l2_ack = 1'b0;
            #1;
            chk($sformatf("t3_hit_way%0d", w), {72'd0, stall, l2_req}, 74'd0);
        end
        do_miss("t3_plru_a", 32'h0000_4030, 4'hF, 4'h0, 26'h0, 0, 2'd0, 1'b0, 6);
        do_miss("t3_plru_b", 32'h0000_5030, 4'hF, 4'h0, 26'h0, 0, 2'd2, 1'b0, 6);

        // 3 wait cycles per word: 6 + 12 stall cycles, address held while waiting
        do_miss("t4_wait", 32'h0000_6020, 4'h0, 4'h0, 26'h0, 3, 2'd0, 1'b0, 18);

        // reset during refill beat 2
        @(negedge CLK);
        cpu_rd = 1'b1; cpu_addr = 32'h0000_7010; hit = 1'b0; set_valid = 4'h0;
        set_dirty = 4'h0; l2_ack = 1'b0;
        @(negedge CLK); l2_ack = 1'b1;
        @(negedge CLK); l2_ack = 1'b1;
        @(negedge CLK); l2_ack = 1'b0;
        #1;
        chk("t5_beat2_addr", {42'd0, l2_req, l2_addr}, {42'd0, 1'b1, 32'h0000_7018});
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1; cpu_rd = 1'b0;
        #1;
        chk("t5_after_reset", act, 74'd0);
        do_miss("t5_replay", 32'h0000_7010, 4'h0, 4'h0, 26'h0, 0, 2'd0, 1'b0, 6);

        @(negedge CLK);
        cpu_rd = 1'b0; hit = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
